commit_trace_buffer: RTL and testbench

Parametrised hardware trace capture for the sequential RISC-V datapath. It records one commit record (PC, destination register, write data, memory address) per retired instruction into an on-chip ring buffer. Capture can be gated by a PC-match trigger, and records drain through a valid/ready read port. It sits beside `datapath`, fed from its retire-point signals, and replaces printf-style per-cycle monitoring with a synthesizable capture path.

---
 rtl/trace_pkg.sv | 25 ++
 rtl/trace_fifo_mem.sv | 26 ++
 rtl/commit_trace_buffer.sv | 161 ++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the commit trace capture path.
package trace_pkg;

  localparam int unsigned TRACE_XLEN   = 64;
  localparam int unsigned TRACE_REG_AW = 5;

  // Capture session state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_e;

  // One retired-instruction record at the default datapath widths.
  typedef struct packed {
    logic [TRACE_XLEN-1:0]   pc;
    logic [TRACE_REG_AW-1:0] rd;
    logic [TRACE_XLEN-1:0]   wdata;
    logic                    we;
    logic                    mem_we;
    logic [TRACE_XLEN-1:0]   mem_addr;
  } commit_rec_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Record storage: DEPTH x W register array, synchronous write, asynchronous head read.
module trace_fifo_mem #(
  parameter  int unsigned W     = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Store the incoming record at the write pointer.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace capture: arm/trigger/stop control, ring-buffer pointers and show-ahead read port.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter  int unsigned XLEN   = 64,
  parameter  int unsigned REG_AW = 5,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   commit_pc,
  input  logic [REG_AW-1:0] commit_rd,
  input  logic [XLEN-1:0]   commit_wdata,
  input  logic              commit_we,
  input  logic              commit_mem_we,
  input  logic [XLEN-1:0]   commit_mem_addr,
  input  logic              arm,
  input  logic              stop,
  input  logic              trigger_en,
  input  logic [XLEN-1:0]   trigger_pc,
  input  logic              wrap_mode,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [XLEN-1:0]   rd_pc,
  output logic [REG_AW-1:0] rd_rd,
  output logic [XLEN-1:0]   rd_wdata,
  output logic              rd_we,
  output logic              rd_mem_we,
  output logic [XLEN-1:0]   rd_mem_addr,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = 3 * XLEN + REG_AW + 2;

  trace_state_e    state, state_nx;
  logic [AW-1:0]   wptr, wptr_nx, rptr, rptr_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            ovf, ovf_nx;
  logic            wrap_q, wrap_nx;
  logic            trig_en_q, trig_en_nx;
  logic [XLEN-1:0] trig_pc_q, trig_pc_nx;
  logic            mem_we, push_req, pop, full;
  logic [RW-1:0]   wrec, head;

  assign wrec     = {commit_pc, commit_rd, commit_wdata, commit_we, commit_mem_we, commit_mem_addr};
  assign full     = (cnt == CW'(DEPTH));
  assign rd_valid = (cnt != '0);
  assign pop      = rd_valid && rd_ready;
  assign count    = cnt;
  assign overflow = ovf;
  assign busy     = (state == ARMED) || (state == CAPTURE);

  // Head fields are forced to zero while empty so the port never shows stale or uninitialised data.
  assign {rd_pc, rd_rd, rd_wdata, rd_we, rd_mem_we, rd_mem_addr} = rd_valid ? head : '0;

  trace_fifo_mem #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (wrec),
    .raddr (rptr),
    .rdata (head)
  );

  // Next-state, pointer and count update for arm, trigger, capture, drain and overflow.
  always_comb begin
    state_nx   = state;
    wptr_nx    = wptr;
    rptr_nx    = rptr;
    cnt_nx     = cnt;
    ovf_nx     = ovf;
    wrap_nx    = wrap_q;
    trig_en_nx = trig_en_q;
    trig_pc_nx = trig_pc_q;
    mem_we     = 1'b0;
    push_req   = 1'b0;
    if (arm) begin
      wptr_nx    = '0;
      rptr_nx    = '0;
      cnt_nx     = '0;
      ovf_nx     = 1'b0;
      wrap_nx    = wrap_mode;
      trig_en_nx = trigger_en;
      trig_pc_nx = trigger_pc;
      state_nx   = trigger_en ? ARMED : CAPTURE;
    end else begin
      case (state)
        ARMED: begin
          if (stop) begin
            state_nx = DONE;
          end else if (commit_valid && (commit_pc == trig_pc_q)) begin
            push_req = 1'b1;
            state_nx = CAPTURE;
          end
        end
        CAPTURE: begin
          if (stop) begin
            state_nx = DONE;
          end else begin
            push_req = commit_valid;
          end
        end
        default: ;
      endcase
      if (pop) begin
        rptr_nx = rptr + 1'b1;
      end
      // A full push with no simultaneous pop either evicts the oldest record or ends the session.
      if (push_req && full && !pop) begin
        ovf_nx = 1'b1;
        if (wrap_q) begin
          mem_we  = 1'b1;
          wptr_nx = wptr + 1'b1;
          rptr_nx = rptr + 1'b1;
        end else begin
          state_nx = DONE;
        end
      end else if (push_req) begin
        mem_we  = 1'b1;
        wptr_nx = wptr + 1'b1;
        if (!pop) begin
          cnt_nx = cnt + 1'b1;
        end
      end else if (pop) begin
        cnt_nx = cnt - 1'b1;
      end
    end
  end

  // State, pointer, count and session-configuration registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      wrap_q    <= 1'b0;
      trig_en_q <= 1'b0;
      trig_pc_q <= '0;
    end else begin
      state     <= state_nx;
      wptr      <= wptr_nx;
      rptr      <= rptr_nx;
      cnt       <= cnt_nx;
      ovf       <= ovf_nx;
      wrap_q    <= wrap_nx;
      trig_en_q <= trig_en_nx;
      trig_pc_q <= trig_pc_nx;
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: vector table, directed corner cases, random vs queue model.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [4:0]  commit_rd;
  logic [63:0] commit_wdata;
  logic        commit_we;
  logic        commit_mem_we;
  logic [63:0] commit_mem_addr;
  logic        arm, stop, trigger_en, wrap_mode, rd_ready;
  logic [63:0] trigger_pc;
  logic        rd_valid;
  logic [63:0] rd_pc, rd_wdata, rd_mem_addr;
  logic [4:0]  rd_rd;
  logic        rd_we, rd_mem_we;
  logic [4:0]  count;
  logic        overflow, busy;

  always #5 clock = ~clock;

  commit_trace_buffer #(
    .XLEN   (64),
    .REG_AW (5),
    .DEPTH  (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .commit_valid    (commit_valid),
    .commit_pc       (commit_pc),
    .commit_rd       (commit_rd),
    .commit_wdata    (commit_wdata),
    .commit_we       (commit_we),
    .commit_mem_we   (commit_mem_we),
    .commit_mem_addr (commit_mem_addr),
    .arm             (arm),
    .stop            (stop),
    .trigger_en      (trigger_en),
    .trigger_pc      (trigger_pc),
    .wrap_mode       (wrap_mode),
    .rd_ready        (rd_ready),
    .rd_valid        (rd_valid),
    .rd_pc           (rd_pc),
    .rd_rd           (rd_rd),
    .rd_wdata        (rd_wdata),
    .rd_we           (rd_we),
    .rd_mem_we       (rd_mem_we),
    .rd_mem_addr     (rd_mem_addr),
    .count           (count),
    .overflow        (overflow),
    .busy            (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of records plus session state (0 idle, 1 armed, 2 capture, 3 done).
  commit_rec_t mq[$];
  int          mstate;
  bit          movf, mwrap;
  logic [63:0] mtpc;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Record fields derived from the PC so every field carries distinct data.
  function automatic commit_rec_t mk(logic [63:0] pc);
    commit_rec_t r;
    r.pc       = pc;
    r.rd       = pc[6:2];
    r.wdata    = pc * 64'd3 + 64'h1234_5678_0000_0001;
    r.we       = pc[2];
    r.mem_we   = pc[3];
    r.mem_addr = pc ^ 64'hFFFF_0000_0000_1000;
    return r;
  endfunction

  task automatic drive(bit a, bit ten, logic [63:0] tpc, bit w, bit cv, logic [63:0] pc, bit st, bit rdy);
    commit_rec_t r;
    r = mk(pc);
    reset           = 1'b0;
    arm             = a;
    trigger_en      = ten;
    trigger_pc      = tpc;
    wrap_mode       = w;
    commit_valid    = cv;
    commit_pc       = r.pc;
    commit_rd       = r.rd;
    commit_wdata    = r.wdata;
    commit_we       = r.we;
    commit_mem_we   = r.mem_we;
    commit_mem_addr = r.mem_addr;
    stop            = st;
    rd_ready        = rdy;
  endtask

  function automatic void model_update();
    bit          popped, cap, full0;
    int          st0;
    commit_rec_t cur;
    cur.pc       = commit_pc;
    cur.rd       = commit_rd;
    cur.wdata    = commit_wdata;
    cur.we       = commit_we;
    cur.mem_we   = commit_mem_we;
    cur.mem_addr = commit_mem_addr;
    if (reset) begin
      mq.delete();
      movf   = 1'b0;
      mstate = 0;
    end else if (arm) begin
      mq.delete();
      movf   = 1'b0;
      mwrap  = wrap_mode;
      mtpc   = trigger_pc;
      mstate = trigger_en ? 1 : 2;
    end else begin
      st0    = mstate;
      popped = (mq.size() > 0) && rd_ready;
      full0  = (mq.size() == DEPTH);
      cap    = commit_valid && !stop && (st0 == 2 || (st0 == 1 && commit_pc == mtpc));
      if (popped) void'(mq.pop_front());
      if (cap) begin
        if (st0 == 1) mstate = 2;
        if (full0 && !popped) begin
          movf = 1'b1;
          if (mwrap) begin
            void'(mq.pop_front());
            mq.push_back(cur);
          end else begin
            mstate = 3;
          end
        end else begin
          mq.push_back(cur);
        end
      end
      if (stop && (st0 == 1 || st0 == 2)) mstate = 3;
    end
  endfunction

  function automatic void compare_model();
    chk("count", 64'(count), 64'(mq.size()));
    chk("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
    chk("overflow", 64'(overflow), 64'(movf));
    chk("busy", 64'(busy), 64'(mstate == 1 || mstate == 2));
    if (mq.size() != 0) begin
      chk("rd_pc", rd_pc, mq[0].pc);
      chk("rd_rd", 64'(rd_rd), 64'(mq[0].rd));
      chk("rd_wdata", rd_wdata, mq[0].wdata);
      chk("rd_we", 64'(rd_we), 64'(mq[0].we));
      chk("rd_mem_we", 64'(rd_mem_we), 64'(mq[0].mem_we));
      chk("rd_mem_addr", rd_mem_addr, mq[0].mem_addr);
    end
  endfunction

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit          a, ten;
    logic [63:0] tpc;
    bit          w, cv;
    logic [63:0] pc;
    bit          st, rdy;
    int          e_cnt;
    bit          e_valid, e_busy, e_ovf;
    logic [63:0] e_pc;
  } vec_t;

  function automatic vec_t v(bit a, bit ten, logic [63:0] tpc, bit w, bit cv, logic [63:0] pc,
                             bit st, bit rdy, int e_cnt, bit e_valid, bit e_busy, bit e_ovf,
                             logic [63:0] e_pc);
    vec_t r;
    r = '{a, ten, tpc, w, cv, pc, st, rdy, e_cnt, e_valid, e_busy, e_ovf, e_pc};
    return r;
  endfunction

  vec_t tbl[22];

  initial begin
    // Directed vectors: untriggered capture, drain, then a PC-triggered session.
    tbl[0]  = v(1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
    tbl[1]  = v(0, 0, 0,  0, 1, 0,  0, 0, 1, 1, 1, 0, 0);
    tbl[2]  = v(0, 0, 0,  0, 1, 4,  0, 0, 2, 1, 1, 0, 0);
    tbl[3]  = v(0, 0, 0,  0, 1, 8,  0, 0, 3, 1, 1, 0, 0);
    tbl[4]  = v(0, 0, 0,  0, 1, 12, 0, 0, 4, 1, 1, 0, 0);
    tbl[5]  = v(0, 0, 0,  0, 1, 16, 0, 0, 5, 1, 1, 0, 0);
    tbl[6]  = v(0, 0, 0,  0, 1, 20, 1, 0, 5, 1, 0, 0, 0);
    tbl[7]  = v(0, 0, 0,  0, 0, 0,  0, 1, 4, 1, 0, 0, 4);
    tbl[8]  = v(0, 0, 0,  0, 0, 0,  0, 1, 3, 1, 0, 0, 8);
    tbl[9]  = v(0, 0, 0,  0, 0, 0,  0, 1, 2, 1, 0, 0, 12);
    tbl[10] = v(0, 0, 0,  0, 0, 0,  0, 1, 1, 1, 0, 0, 16);
    tbl[11] = v(0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
    tbl[12] = v(0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
    tbl[13] = v(1, 1, 12, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tbl[14 + i] = v(0, 0, 0, 0, 1, 64'(i * 4), 0, 0, (i < 3) ? 0 : i - 2, i >= 3, 1, 0, 12);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    step();
    chk("reset_count", 64'(count), 0);
    chk("reset_valid", 64'(rd_valid), 0);
    chk("reset_ovf", 64'(overflow), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_rd_pc", rd_pc, 0);
    chk("reset_rd_wdata", rd_wdata, 0);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].a, tbl[i].ten, tbl[i].tpc, tbl[i].w, tbl[i].cv, tbl[i].pc, tbl[i].st, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_valid", i), 64'(rd_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'(tbl[i].e_ovf));
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_pc", i), rd_pc, tbl[i].e_pc);
    end

    // Stop mode: 20 commits into a 16-deep buffer end the session with the overflow flag.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 1, 64'(i * 4), 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stopmode_count", 64'(count), 16);
    chk("stopmode_ovf", 64'(overflow), 1);
    chk("stopmode_busy", 64'(busy), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("stopmode_drain%0d", i), rd_pc, 64'(i * 4));
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      step();
    end
    chk("stopmode_empty", 64'(rd_valid), 0);

    // Wrap mode: oldest records are overwritten and capture continues.
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 1, 64'(i * 4), 0, 0);
      step();
    end
    chk("wrap_count", 64'(count), 16);
    chk("wrap_head", rd_pc, 16);
    chk("wrap_ovf", 64'(overflow), 1);
    chk("wrap_busy", 64'(busy), 1);

    // Full buffer, simultaneous push and pop: no overflow, oldest leaves.
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 1, 64'(i * 4), 0, 0);
      step();
    end
    chk("pushpop_pre_count", 64'(count), 16);
    chk("pushpop_pre_head", rd_pc, 0);
    drive(0, 0, 0, 0, 1, 64, 0, 1);
    step();
    chk("pushpop_count", 64'(count), 16);
    chk("pushpop_ovf", 64'(overflow), 0);
    chk("pushpop_head", rd_pc, 4);

    // Reset in mid-capture clears everything; later commits are ignored.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 0, 1, 64'(100 + i * 4), 0, 0);
      step();
    end
    chk("midreset_pre_count", 64'(count), 7);
    drive(0, 0, 0, 0, 1, 200, 0, 0);
    reset = 1'b1;
    step();
    chk("midreset_count", 64'(count), 0);
    chk("midreset_valid", 64'(rd_valid), 0);
    chk("midreset_ovf", 64'(overflow), 0);
    chk("midreset_busy", 64'(busy), 0);
    drive(0, 0, 0, 0, 1, 204, 0, 0);
    step();
    chk("midreset_ignore_count", 64'(count), 0);
    chk("midreset_ignore_busy", 64'(busy), 0);

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, 64'($urandom_range(0, 15) * 4),
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6, 64'($urandom_range(0, 15) * 4),
            $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 4);
      if ($urandom_range(0, 249) == 0) reset = 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
